// File: rtl/xmt_pkg.sv
// Shared encodings for the serial transmitter: parity modes, FSM states and
// the parity-bit helper used at the end of the data field.
package xmt_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Turns the XOR of all data bits into the parity bit for the selected mode.
    function automatic logic par_bit(input logic [1:0] mode, input logic xor_all);
        case (mode)
            PAR_EVEN: par_bit = xor_all;
            PAR_ODD:  par_bit = ~xor_all;
            PAR_MARK: par_bit = 1'b1;
            default:  par_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/xmt_fifo_buf.sv
// Synchronous FIFO with registered occupancy; a push while full is ignored and
// a pop while empty is ignored, so push and pop may be asserted together.
module xmt_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // full is judged on the registered level, before any same-cycle pop
    assign full    = (level_r == LVL_W'(DEPTH));
    assign empty   = (level_r == '0);
    assign level   = level_r;
    assign wr_en_s = push & ~full;
    assign rd_en_s = pop & ~empty;
    assign dout    = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/xmt_fifo.sv
// Serial-line transmitter with input FIFO: configurable data width, parity and
// stop bits, with frames sent back to back while characters are queued.
module xmt_fifo
    import xmt_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          bit_len,
    input  logic [1:0]           parity,
    input  logic                 stop2,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] parallel_in,
    output logic                 full,
    output logic                 empty,
    output logic [LVL_W-1:0]     level,
    output logic                 ovr,
    output logic                 serial_out
);

    localparam int IDX_W = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0] fifo_dout_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic                 last_stop_s;

    logic [2:0]           state_r;
    logic [15:0]          timer_r;
    logic [15:0]          bit_len_r;
    logic [1:0]           par_mode_r;
    logic                 stop2_r;
    logic                 stop_cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 par_acc_r;
    logic                 serial_r;
    logic                 ovr_r;

    xmt_fifo_buf #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (load),
        .pop   (pop_s),
        .din   (parallel_in),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level)
    );

    assign bit_end_s   = (timer_r == 16'd0);
    assign last_stop_s = bit_end_s && (state_r == ST_STOP) && (stop_cnt_r || !stop2_r);
    // A new frame launches from IDLE or straight out of the final stop bit
    assign pop_s       = !fifo_empty_s && ((state_r == ST_IDLE) || last_stop_s);

    assign full       = fifo_full_s;
    assign empty      = fifo_empty_s && (state_r == ST_IDLE);
    assign ovr        = ovr_r;
    assign serial_out = serial_r;

    // Sticky overrun flag: a load that finds the FIFO full is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r | (load & fifo_full_s);
        end
    end

    // Frame FSM, bit timer, shift register and parity accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= 16'd0;
            bit_len_r  <= 16'd0;
            par_mode_r <= PAR_NONE;
            stop2_r    <= 1'b0;
            stop_cnt_r <= 1'b0;
            idx_r      <= '0;
            shreg_r    <= '0;
            par_acc_r  <= 1'b0;
            serial_r   <= 1'b1;
        end else if (pop_s) begin
            state_r    <= ST_START;
            timer_r    <= bit_len;
            bit_len_r  <= bit_len;
            par_mode_r <= parity;
            stop2_r    <= stop2;
            stop_cnt_r <= 1'b0;
            idx_r      <= '0;
            shreg_r    <= fifo_dout_s;
            par_acc_r  <= 1'b0;
            serial_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    serial_r <= 1'b1;
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r  <= ST_DATA;
                        idx_r    <= '0;
                        timer_r  <= bit_len_r;
                        serial_r <= shreg_r[0];
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        timer_r   <= bit_len_r;
                        par_acc_r <= par_acc_r ^ shreg_r[0];
                        if (idx_r == IDX_W'(DATA_BITS - 1)) begin
                            if (par_mode_r != PAR_NONE) begin
                                state_r  <= ST_PAR;
                                serial_r <= par_bit(par_mode_r, par_acc_r ^ shreg_r[0]);
                            end else begin
                                state_r  <= ST_STOP;
                                serial_r <= 1'b1;
                            end
                        end else begin
                            idx_r    <= idx_r + IDX_W'(1);
                            shreg_r  <= shreg_r >> 1;
                            serial_r <= shreg_r[1];
                        end
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                ST_PAR: begin
                    if (bit_end_s) begin
                        state_r    <= ST_STOP;
                        stop_cnt_r <= 1'b0;
                        timer_r    <= bit_len_r;
                        serial_r   <= 1'b1;
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (stop2_r && !stop_cnt_r) begin
                            stop_cnt_r <= 1'b1;
                            timer_r    <= bit_len_r;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                    serial_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    serial_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xmt_fifo.sv
// Scoreboard bench for xmt_fifo: stimulus queues hand-computed frames, a
// monitor decodes the TxD line cycle by cycle and compares against the queue.
module tb_xmt_fifo;
    import xmt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bit_len;
    logic [1:0]  parity;
    logic        stop2;
    logic        load_a, load_b;
    logic [7:0]  din_a;
    logic [6:0]  din_b;
    logic        full_a, empty_a, ovr_a, serial_a;
    logic [4:0]  level_a;
    logic        full_b, empty_b, ovr_b, serial_b;
    logic [2:0]  level_b;
    logic        sel, mon_en, mon_busy, mon_line;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          bl;
        int          gap;
    } frame_t;
    frame_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mon_line = sel ? serial_b : serial_a;

    xmt_fifo dut_a (
        .clk(clk), .rst_n(rst_n), .bit_len(bit_len), .parity(parity), .stop2(stop2),
        .load(load_a), .parallel_in(din_a), .full(full_a), .empty(empty_a),
        .level(level_a), .ovr(ovr_a), .serial_out(serial_a)
    );

    xmt_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_len(bit_len), .parity(parity), .stop2(stop2),
        .load(load_b), .parallel_in(din_b), .full(full_b), .empty(empty_b),
        .level(level_b), .ovr(ovr_b), .serial_out(serial_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] bits, input int nbits, input int bl, input int gap);
        frame_t f;
        f.bits = bits; f.nbits = nbits; f.bl = bl; f.gap = gap;
        exp_q.push_back(f);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy || !empty_a || !empty_b) && n < bound) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n >= bound), 32'd0);
    endtask

    // Monitor: decode each frame on the selected line and compare with the queue.
    initial begin : monitor
        frame_t      e;
        logic [15:0] obs;
        bit          bad;
        int          start_cyc;
        int          last_end;
        mon_busy = 1'b0;
        last_end = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && mon_line == 1'b0) begin
                mon_busy  = 1'b1;
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
                    for (int n = 0; n < 4096 && mon_line == 1'b0; n++) @(negedge clk);
                end else begin
                    e   = exp_q.pop_front();
                    bad = 1'b0;
                    obs = 16'd0;
                    for (int b = 0; b < e.nbits; b++) begin
                        for (int c = 0; c <= e.bl; c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            obs[b] = mon_line;
                            if (mon_line !== e.bits[b]) bad = 1'b1;
                        end
                    end
                    checks++;
                    if (bad) begin
                        failures++;
                        $display("FAIL frame_bits: got %b, required %b (bit_len %0d)", obs, e.bits, e.bl);
                    end
                    if (e.gap >= 0) begin
                        checks++;
                        if (start_cyc - last_end - 1 != e.gap) begin
                            failures++;
                            $display("FAIL frame_gap: got %0d idle cycles, required %0d",
                                     start_cyc - last_end - 1, e.gap);
                        end
                    end
                    last_end = cyc;
                end
                mon_busy = 1'b0;
            end
        end
    end

    logic [6:0] t4_din [5]  = '{7'h21, 7'h32, 7'h43, 7'h54, 7'h65};
    int         t4_lvl [5]  = '{1, 2, 3, 4, 4};
    int         t4_full [5] = '{0, 0, 0, 1, 1};
    int         t4_ovr [5]  = '{0, 0, 0, 0, 1};
    int         zeros;

    initial begin
        rst_n = 1'b0; bit_len = 16'd3; parity = PAR_NONE; stop2 = 1'b0;
        load_a = 1'b0; load_b = 1'b0; din_a = 8'h00; din_b = 7'h00;
        sel = 1'b0; mon_en = 1'b1;
        repeat (3) tick();
        check("rst_serial", 32'(serial_a), 32'd1);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_ovr", 32'(ovr_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // 8N1, 4-cycle bits, 0xA5
        push_exp(16'b1101001010, 10, 3, -1);
        din_a = 8'hA5; load_a = 1'b1; tick(); load_a = 1'b0;
        check("t1_level_load", 32'(level_a), 32'd1);
        check("t1_empty_load", 32'(empty_a), 32'd0);
        tick();
        check("t1_level_pop", 32'(level_a), 32'd0);
        check("t1_start_bit", 32'(serial_a), 32'd0);
        repeat (39) tick();
        check("t1_empty_before_end", 32'(empty_a), 32'd0);
        tick();
        check("t1_empty_at_end", 32'(empty_a), 32'd1);
        wait_drain(200);

        // even then odd parity, 1-cycle bits, back to back
        bit_len = 16'd0; parity = PAR_EVEN;
        push_exp(16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 0, -1);
        push_exp(16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 0, 0);
        din_a = 8'hA5; load_a = 1'b1; tick(); load_a = 1'b0;
        tick();
        parity = PAR_ODD; load_a = 1'b1; tick(); load_a = 1'b0;
        check("t2_level_queued", 32'(level_a), 32'd1);
        wait_drain(200);

        // bit_len changed mid-frame applies only to the next frame
        bit_len = 16'd3; parity = PAR_NONE;
        push_exp(16'({1'b1, 8'h3C, 1'b0}), 10, 3, -1);
        push_exp(16'({1'b1, 8'hC3, 1'b0}), 10, 7, 0);
        din_a = 8'h3C; load_a = 1'b1; tick(); load_a = 1'b0;
        repeat (6) tick();
        bit_len = 16'd7; din_a = 8'hC3; load_a = 1'b1; tick(); load_a = 1'b0;
        wait_drain(400);

        // 7 data bits, two stop bits, 2-cycle bits, back to back
        sel = 1'b1; bit_len = 16'd1; stop2 = 1'b1;
        push_exp(16'({2'b11, 7'h41, 1'b0}), 10, 1, -1);
        push_exp(16'({2'b11, 7'h42, 1'b0}), 10, 1, 0);
        din_b = 7'h41; load_b = 1'b1; tick();
        check("t3_level_first", 32'(level_b), 32'd1);
        din_b = 7'h42; tick(); load_b = 1'b0;
        check("t3_level_push_pop", 32'(level_b), 32'd1);
        repeat (19) tick();
        check("t3_level_before_end", 32'(level_b), 32'd1);
        tick();
        check("t3_level_after_pop", 32'(level_b), 32'd0);
        check("t3_busy", 32'(empty_b), 32'd0);
        wait_drain(400);

        // depth-4 FIFO overrun while the first frame is in START
        stop2 = 1'b0; bit_len = 16'd7;
        push_exp(16'({1'b1, 7'h10, 1'b0}), 9, 7, -1);
        for (int i = 0; i < 4; i++) push_exp(16'({1'b1, t4_din[i], 1'b0}), 9, 7, 0);
        din_b = 7'h10; load_b = 1'b1; tick(); load_b = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            din_b = t4_din[i]; load_b = 1'b1; tick();
            check($sformatf("t4_level_%0d", i), 32'(level_b), 32'(t4_lvl[i]));
            check($sformatf("t4_full_%0d", i), 32'(full_b), 32'(t4_full[i]));
            check($sformatf("t4_ovr_%0d", i), 32'(ovr_b), 32'(t4_ovr[i]));
        end
        load_b = 1'b0;
        wait_drain(2000);
        check("t4_ovr_sticky", 32'(ovr_b), 32'd1);
        check("t4_full_clear", 32'(full_b), 32'd0);

        // reset mid-DATA with three characters queued
        sel = 1'b0; mon_en = 1'b0; bit_len = 16'd3;
        din_a = 8'h00; load_a = 1'b1; tick();
        din_a = 8'h01; tick();
        din_a = 8'h02; tick();
        din_a = 8'h03; tick(); load_a = 1'b0;
        repeat (4) tick();
        check("t5_pre_level", 32'(level_a), 32'd3);
        check("t5_pre_serial", 32'(serial_a), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_serial", 32'(serial_a), 32'd1);
        check("t5_rst_level", 32'(level_a), 32'd0);
        check("t5_rst_empty", 32'(empty_a), 32'd1);
        check("t5_rst_ovr", 32'(ovr_b), 32'd0);
        tick();
        rst_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (serial_a !== 1'b1) zeros++;
        end
        check("t5_no_frame_after_reset", 32'(zeros), 32'd0);
        check("t5_empty_after", 32'(empty_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
